// File: rtl/fp_mult_pipe.sv
// fp_mult_pipe: pipelined sign/exponent/mantissa multiplier with flush-to-zero and valid/ready flow control.
// Define FP_MULT_PIPE_RNE_EN for round-to-nearest-even; the default build truncates the mantissa.
module fp_mult_pipe #(
  parameter int EXP_W  = 8,
  parameter int MAN_W  = 23,
  parameter int STAGES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] result,
  output logic                 exception,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int DW     = 1 + EXP_W + MAN_W;
  localparam int PW     = 2*MAN_W + 2;
  localparam int XW     = EXP_W + 2;
  localparam int BIAS_I = (1 << (EXP_W-1)) - 1;
  localparam logic signed [XW-1:0] BIAS  = BIAS_I[XW-1:0];
  localparam logic signed [XW-1:0] E_ONE = {{(XW-1){1'b0}}, 1'b1};
  localparam logic signed [XW-1:0] E_MAX = {2'b00, {EXP_W{1'b1}}};

`ifdef FP_MULT_PIPE_RNE_EN
  localparam logic RNE = 1'b1;
`else
  localparam logic RNE = 1'b0;
`endif

  typedef struct packed {
    logic          sign;
    logic          exc;
    logic          zero;
    logic [XW-1:0] e_sum;
    logic [PW-1:0] prod;
  } mid_t;

  typedef struct packed {
    logic [DW-1:0] res;
    logic          exc;
    logic          ovf;
    logic          unf;
  } out_t;

  function automatic mid_t mul_front(input logic [DW-1:0] x, input logic [DW-1:0] y);
    mid_t             m;
    logic [EXP_W-1:0] ex;
    logic [EXP_W-1:0] ey;
    logic [MAN_W:0]   mx;
    logic [MAN_W:0]   my;
    ex      = x[MAN_W +: EXP_W];
    ey      = y[MAN_W +: EXP_W];
    mx      = {|ex, x[MAN_W-1:0]};
    my      = {|ey, y[MAN_W-1:0]};
    m.sign  = x[DW-1] ^ y[DW-1];
    m.exc   = (&ex) | (&ey);
    m.zero  = (ex == '0) | (ey == '0);
    m.e_sum = $signed({2'b00, ex}) + $signed({2'b00, ey}) - BIAS;
    m.prod  = {{(MAN_W+1){1'b0}}, mx} * {{(MAN_W+1){1'b0}}, my};
    return m;
  endfunction

  function automatic out_t mul_back(input mid_t m);
    out_t                   o;
    logic [MAN_W-1:0]       frac;
    logic [MAN_W:0]         fr;
    logic                   guard;
    logic                   sticky;
    logic                   rnd;
    logic signed [XW-1:0]   e;
    o = '0;
    // A product in [2,4) takes its fraction one bit higher and bumps the exponent
    if (m.prod[PW-1]) begin
      frac   = m.prod[2*MAN_W -: MAN_W];
      guard  = m.prod[MAN_W];
      sticky = |m.prod[MAN_W-1:0];
      e      = $signed(m.e_sum) + E_ONE;
    end else begin
      frac   = m.prod[2*MAN_W-1 -: MAN_W];
      guard  = m.prod[MAN_W-1];
      sticky = |m.prod[MAN_W-2:0];
      e      = $signed(m.e_sum);
    end
    rnd = RNE & guard & (sticky | frac[0]);
    fr  = {1'b0, frac} + {{MAN_W{1'b0}}, rnd};
    // Carry out of rounding leaves a zero fraction; only the exponent moves
    if (fr[MAN_W]) e = e + E_ONE;
    if (m.exc) begin
      o.res = {m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o.exc = 1'b1;
    end else if (m.zero) begin
      o.res = {m.sign, {(DW-1){1'b0}}};
    end else if (e >= E_MAX) begin
      o.res = {m.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      o.ovf = 1'b1;
    end else if (e[XW-1] || e == '0) begin
      o.res = {m.sign, {(DW-1){1'b0}}};
      o.unf = 1'b1;
    end else begin
      o.res = {m.sign, e[EXP_W-1:0], fr[MAN_W-1:0]};
    end
    return o;
  endfunction

  logic [STAGES-1:0] r_vld;
  logic              w_adv;
  out_t              w_out;

  assign w_adv     = !r_vld[STAGES-1] || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = r_vld[STAGES-1];
  assign result    = w_out.res;
  assign exception = w_out.exc;
  assign overflow  = w_out.ovf;
  assign underflow = w_out.unf;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld <= '0;
    end else if (w_adv) begin
      for (int unsigned i = STAGES-1; i > 0; i--) r_vld[i] <= r_vld[i-1];
      r_vld[0] <= in_valid;
    end
  end

  generate
    if (STAGES == 1) begin : g_s1
      out_t r_out;
      always_ff @(posedge clk) begin
        if (reset)      r_out <= '0;
        else if (w_adv) r_out <= mul_back(mul_front(a, b));
      end
      assign w_out = r_out;
    end else begin : g_sn
      logic [2*DW-1:0] r_ops;
      always_ff @(posedge clk) begin
        if (w_adv) r_ops <= {a, b};
      end
      if (STAGES == 2) begin : g_s2
        out_t r_out;
        always_ff @(posedge clk) begin
          if (reset)      r_out <= '0;
          else if (w_adv) r_out <= mul_back(mul_front(r_ops[2*DW-1:DW], r_ops[DW-1:0]));
        end
        assign w_out = r_out;
      end else begin : g_s3
        mid_t r_mid;
        out_t r_pipe [STAGES-2];
        always_ff @(posedge clk) begin
          if (w_adv) r_mid <= mul_front(r_ops[2*DW-1:DW], r_ops[DW-1:0]);
        end
        always_ff @(posedge clk) begin
          if (reset) begin
            for (int unsigned k = 0; k < STAGES-2; k++) r_pipe[k] <= '0;
          end else if (w_adv) begin
            r_pipe[0] <= mul_back(r_mid);
            for (int unsigned k = 1; k < STAGES-2; k++) r_pipe[k] <= r_pipe[k-1];
          end
        end
        assign w_out = r_pipe[STAGES-3];
      end
    end
  endgenerate

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe: vector table through a scoreboard, latency, stall burst and reset flush.
module tb_fp_mult_pipe;
  localparam int EXP_W  = 8;
  localparam int MAN_W  = 23;
  localparam int STAGES = 3;
  localparam int DW     = 1 + EXP_W + MAN_W;

  logic          clk = 1'b0;
  logic          reset, in_valid, in_ready, out_valid, out_ready;
  logic          exception, overflow, underflow;
  logic [DW-1:0] a, b, result;

  typedef struct { logic [31:0] a; logic [31:0] b; logic [31:0] res; logic [2:0] flg; } vec_t;
  typedef struct { int id; logic [31:0] res; logic [2:0] flg; } exp_t;

  vec_t        vecs[$];
  exp_t        exp_q[$];
  exp_t        cur_exp;
  int          checks = 0;
  int          errors = 0;
  int          npop   = 0;
  logic        held_v = 1'b0;
  logic [34:0] held;
  logic        burst_done;

  fp_mult_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .STAGES(STAGES)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .exception(exception), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endfunction

  task automatic add(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vr, input logic [2:0] vf);
    vec_t v;
    v.a = va; v.b = vb; v.res = vr; v.flg = vf;
    vecs.push_back(v);
  endtask

  task automatic mon_step();
    exp_t e;
    if (reset) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) chk("stall_hold", {out_valid, result, exception, overflow, underflow}, {1'b1, held});
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        held_v = 1'b0;
        npop++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got res=%h, want no output", result);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if ({result, exception, overflow, underflow} !== {e.res, e.flg}) begin
            errors++;
            $display("FAIL vec%0d: got res=%h flags=%b, want res=%h flags=%b",
                     e.id, result, {exception, overflow, underflow}, e.res, e.flg);
          end
          chk($sformatf("one_flag_vec%0d", e.id), 64'($countones({exception, overflow, underflow}) <= 1), 64'd1);
        end
      end else if (out_valid) begin
        held_v = 1'b1;
        held   = {result, exception, overflow, underflow};
      end else begin
        held_v = 1'b0;
      end
    end
  endtask

  task automatic send(input int id);
    logic ok = 1'b0;
    a = vecs[id].a; b = vecs[id].b;
    cur_exp.id = id; cur_exp.res = vecs[id].res; cur_exp.flg = vecs[id].flg;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout vec%0d: got in_ready=0, want 1", id);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  task automatic lat_check(input int id);
    send(id);
    for (int j = 0; j < STAGES; j++) begin
      @(negedge clk);
      chk($sformatf("latency_vec%0d_cyc%0d", id, j), 64'(out_valid), 64'(j == STAGES-1));
    end
    drain();
  endtask

  initial begin
    int   base;
    logic stale;
    reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    cur_exp.id = 0; cur_exp.res = '0; cur_exp.flg = '0;
    held = '0; burst_done = 1'b0;

    //   a             b             result        {exc,ovf,unf}
    add(32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);
    add(32'h40400000, 32'hC0000000, 32'hC0C00000, 3'b000);
`ifdef FP_MULT_PIPE_RNE_EN
    add(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 3'b000);
`else
    add(32'h3F800001, 32'h3FC00000, 32'h3FC00001, 3'b000);
`endif
    add(32'h7F000000, 32'h40000000, 32'h7F800000, 3'b010);
    add(32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
    add(32'h7F800000, 32'h3F800000, 32'h7F800000, 3'b100);
    add(32'h00000000, 32'hC0000000, 32'h80000000, 3'b000);
    add(32'h40000000, 32'h40000000, 32'h40800000, 3'b000);
    add(32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000);
    add(32'hBF800000, 32'hBF800000, 32'h3F800000, 3'b000);
    add(32'h3F000000, 32'h40800000, 32'h40000000, 3'b000);
    add(32'h40400000, 32'h40400000, 32'h41100000, 3'b000);
    add(32'h7FC00000, 32'h00000000, 32'h7F800000, 3'b100);
    add(32'hFF800000, 32'h40000000, 32'hFF800000, 3'b100);
    add(32'h00400000, 32'h40000000, 32'h00000000, 3'b000);
    add(32'h00800000, 32'h3F800000, 32'h00800000, 3'b000);
    add(32'h7F000000, 32'h3FFFFFFF, 32'h7F7FFFFF, 3'b000);
    add(32'h7F400000, 32'h3FC00000, 32'h7F800000, 3'b010);
    add(32'hFF000000, 32'h40000000, 32'hFF800000, 3'b010);
    add(32'h80800000, 32'h3F000000, 32'h80000000, 3'b001);
    add(32'h3F800003, 32'h3FC00000, 32'h3FC00004, 3'b000);
`ifdef FP_MULT_PIPE_RNE_EN
    add(32'h3F800001, 32'h3FE00000, 32'h3FE00002, 3'b000);
`else
    add(32'h3F800001, 32'h3FE00000, 32'h3FE00001, 3'b000);
`endif

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_flags", 64'({exception, overflow, underflow}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b0;
    chk("in_ready_after_reset", 64'(in_ready), 64'd1);
    out_ready = 1'b1;

    lat_check(0);
    lat_check(1);

    for (int i = 0; i < vecs.size(); i++) send(i);
    drain();

    // Back-to-back burst while the sink randomly stalls
    base = npop;
    burst_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i);
        burst_done = 1'b1;
      end
      begin
        for (int k = 0; k < 600 && !(burst_done && exp_q.size() == 0); k++) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 1) == 1);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk("burst_count", 64'(npop - base), 64'd8);

    // Reset with two transactions in flight
    send(3);
    send(7);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midreset_out_valid", 64'(out_valid), 64'd0);
    chk("midreset_result", 64'(result), 64'd0);
    chk("midreset_flags", 64'({exception, overflow, underflow}), 64'd0);
    reset = 1'b0; out_ready = 1'b0;
    chk("in_ready_after_midreset", 64'(in_ready), 64'd1);
    stale = 1'b0;
    repeat (8) begin
      @(negedge clk);
      stale = stale | out_valid;
    end
    chk("no_stale_output", 64'(stale), 64'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
